// File: rtl/serial_uart_rx.sv
// UART receiver: 8 data bits LSB first, 16x oversampling with a 3-sample majority
// vote, optional odd/even parity, and strobed byte output with error pulses.
module serial_uart_rx #(
  parameter int unsigned TICK_DIV   = 1,
  parameter int unsigned PARITY     = 0,
  parameter bit          STOP_CHECK = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       serial_in,
  output logic [7:0] as_data_o,
  output logic       as_dstrb_o,
  output logic       as_busy_o,
  output logic       frame_err_o,
  output logic       parity_err_o
);

  localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);
  localparam bit          HAS_PAR  = (PARITY == 1) || (PARITY == 2);
  localparam bit          ODD_PAR  = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_sync1;
  logic        r_rx_s;
  logic        r_rx_d;
  logic [15:0] r_div;
  logic [3:0]  r_smp;
  logic [2:0]  r_bitcnt;
  logic        r_s7;
  logic        r_s8;
  logic [7:0]  r_shift;
  logic        r_par_err;

  logic        w_start;
  logic        w_tick;
  logic        w_mid;
  logic        w_bound;
  logic        w_maj;
  logic        w_stop_dec;
  logic        w_good;
  logic        w_ferr;
  logic        w_perr;
  logic        w_par_bad;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= serial_in;
      r_rx_s  <= r_sync1;
      r_rx_d  <= r_rx_s;
    end
  end

  // The start edge counts as tick 0; r_smp holds the index of the last tick,
  // so the event for tick N is w_tick with r_smp == N-1.
  assign w_start    = (r_state == S_IDLE) && r_rx_d && !r_rx_s;
  assign w_tick     = (r_state != S_IDLE) && (r_div == DIV_LAST);
  assign w_mid      = w_tick && (r_smp == 4'd8);
  assign w_bound    = w_tick && (r_smp == 4'd15);
  assign w_maj      = (r_s7 & r_s8) | (r_s7 & r_rx_s) | (r_s8 & r_rx_s);
  assign w_par_bad  = HAS_PAR && ((^r_shift ^ w_maj) != ODD_PAR);
  assign w_stop_dec = w_mid && (r_state == S_STOP);
  assign w_ferr     = w_stop_dec && STOP_CHECK && !w_maj;
  assign w_perr     = w_stop_dec && r_par_err;
  assign w_good     = w_stop_dec && !r_par_err && (w_maj || !STOP_CHECK);
  assign as_busy_o  = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_next = S_START;
      S_START: begin
        if (w_mid && w_maj) w_next = S_IDLE;
        else if (w_bound)   w_next = S_DATA;
      end
      S_DATA:   if (w_bound && (r_bitcnt == 3'd7)) w_next = HAS_PAR ? S_PARITY : S_STOP;
      S_PARITY: if (w_bound) w_next = S_STOP;
      S_STOP:   if (w_mid) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div        <= '0;
      r_smp        <= '0;
      r_bitcnt     <= '0;
      r_s7         <= 1'b1;
      r_s8         <= 1'b1;
      r_shift      <= '0;
      r_par_err    <= 1'b0;
      as_data_o    <= '0;
      as_dstrb_o   <= 1'b0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        r_div     <= '0;
        r_smp     <= '0;
        r_bitcnt  <= '0;
        r_par_err <= 1'b0;
      end else begin
        r_div <= (r_div == DIV_LAST) ? '0 : r_div + 16'd1;
        if (w_tick) r_smp <= r_smp + 4'd1;
        if ((r_state == S_DATA) && w_bound) r_bitcnt <= r_bitcnt + 3'd1;
        if ((r_state == S_PARITY) && w_mid) r_par_err <= w_par_bad;
      end
      if (w_tick && (r_smp == 4'd6)) r_s7 <= r_rx_s;
      if (w_tick && (r_smp == 4'd7)) r_s8 <= r_rx_s;
      if ((r_state == S_DATA) && w_mid) r_shift <= {w_maj, r_shift[7:1]};
      as_dstrb_o   <= w_good;
      frame_err_o  <= w_ferr;
      parity_err_o <= w_perr;
      if (w_good) as_data_o <= r_shift;
    end
  end

endmodule
